seg7_scan_driver: RTL and testbench

//  Multiplexed N-digit 7-segment display driver: next generation of the single-digit hex pattern decoder.

---
 rtl/seg7_pkg.sv | 17 +
 rtl/seg7_hex_font.sv | 12 +
 rtl/seg7_scan_driver.sv | 138 +++++++++++++
 tb/tb_seg7_scan_driver.sv | 139 +++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// seg7_pkg: shared segment constants, hex glyph table and scan FSM states
package seg7_pkg;

    localparam logic [7:0] SEG_OFF = 8'hFF;

    localparam logic [127:0] FONT = {
        8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
        8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
    };

    typedef enum logic [1:0] {IDLE, SHOW, GAP} scan_state_e;

    function automatic logic [6:0] hex_font(input logic [3:0] n);
        return FONT[{n, 3'b000} +: 7];
    endfunction

endpackage

// File: rtl/seg7_hex_font.sv
// seg7_hex_font: nibble plus decimal point to active-low {dp,g..a} pattern
module seg7_hex_font
    import seg7_pkg::*;
(
    input  logic [3:0] nib,
    input  logic       dp,
    output logic [7:0] seg
);

    assign seg = {~dp, hex_font(nib)};

endmodule

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: double-buffered N-digit scanned 7-seg driver with dead-time gap; optional LZ_SUPPRESS_EN
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter  int DIGITS   = 8,
    parameter  int CLK_DIV  = 100000,
    parameter  int DEAD_CYC = 16,
    localparam int IDX_W    = $clog2(DIGITS)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   data,
    input  logic [DIGITS-1:0]     dp,
    input  logic [DIGITS-1:0]     blank,
    output logic [7:0]            seg,
    output logic [DIGITS-1:0]     an,
    output logic [IDX_W-1:0]      digit_idx,
    output logic                  frame_done
);

    localparam int MAXC  = CLK_DIV > DEAD_CYC ? CLK_DIV : DEAD_CYC;
    localparam int CNT_W = $clog2(MAXC + 1);

    scan_state_e          st_q, st_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [4*DIGITS-1:0]  sh_data_q, sh_data_d, act_data_q, act_data_d;
    logic [DIGITS-1:0]    sh_dp_q, sh_dp_d, act_dp_q, act_dp_d;
    logic [DIGITS-1:0]    sh_blank_q, sh_blank_d, act_blank_q, act_blank_d;
    logic [7:0]           seg_q, seg_d, glyph;
    logic [DIGITS-1:0]    an_q, an_d, sup;
    logic                 fd_q, fd_d, refresh, last;

    assign last = idx_q == IDX_W'(DIGITS - 1);

    always_comb begin
        st_d    = st_q;
        cnt_d   = cnt_q + 1'b1;
        idx_d   = idx_q;
        fd_d    = 1'b0;
        refresh = 1'b0;
        if (!en) begin
            st_d  = IDLE;
            cnt_d = '0;
            idx_d = '0;
        end else begin
            case (st_q)
                IDLE: begin
                    st_d    = SHOW;
                    cnt_d   = '0;
                    idx_d   = '0;
                    refresh = 1'b1;
                end
                SHOW: if (cnt_q == CNT_W'(CLK_DIV - 1)) begin
                    st_d  = GAP;
                    cnt_d = '0;
                end
                GAP: if (cnt_q == CNT_W'(DEAD_CYC - 1)) begin
                    st_d    = SHOW;
                    cnt_d   = '0;
                    idx_d   = last ? '0 : idx_q + 1'b1;
                    fd_d    = last;
                    refresh = last;
                end
                default: st_d = IDLE;
            endcase
        end
    end

    // a load coinciding with a refresh lands in active directly via the shadow's next value
    assign sh_data_d   = load ? data  : sh_data_q;
    assign sh_dp_d     = load ? dp    : sh_dp_q;
    assign sh_blank_d  = load ? blank : sh_blank_q;
    assign act_data_d  = refresh ? sh_data_d  : act_data_q;
    assign act_dp_d    = refresh ? sh_dp_d    : act_dp_q;
    assign act_blank_d = refresh ? sh_blank_d : act_blank_q;

`ifdef LZ_SUPPRESS_EN
    logic run;
    always_comb begin
        sup = '0;
        run = 1'b1;
        for (int i = DIGITS - 1; i > 0; i--) begin
            run    = run & (act_data_d[4*i +: 4] == 4'h0) & ~act_dp_d[i];
            sup[i] = run;
        end
    end
`else
    assign sup = '0;
`endif

    seg7_hex_font u_font (
        .nib (act_data_d[4*idx_d +: 4]),
        .dp  (act_dp_d[idx_d]),
        .seg (glyph)
    );

    assign seg_d = (st_d == SHOW && !(act_blank_d[idx_d] | sup[idx_d])) ? glyph : SEG_OFF;
    assign an_d  = st_d == SHOW ? ~(DIGITS'(1) << idx_d) : '1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q        <= IDLE;
            cnt_q       <= '0;
            idx_q       <= '0;
            fd_q        <= 1'b0;
            seg_q       <= SEG_OFF;
            an_q        <= '1;
            sh_data_q   <= '0;
            sh_dp_q     <= '0;
            sh_blank_q  <= '0;
            act_data_q  <= '0;
            act_dp_q    <= '0;
            act_blank_q <= '0;
        end else begin
            st_q        <= st_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            fd_q        <= fd_d;
            seg_q       <= seg_d;
            an_q        <= an_d;
            sh_data_q   <= sh_data_d;
            sh_dp_q     <= sh_dp_d;
            sh_blank_q  <= sh_blank_d;
            act_data_q  <= act_data_d;
            act_dp_q    <= act_dp_d;
            act_blank_q <= act_blank_d;
        end
    end

    assign seg        = seg_q;
    assign an         = an_q;
    assign digit_idx  = idx_q;
    assign frame_done = fd_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb_seg7_scan_driver: directed scan/buffer/blank/dp/en/reset checks with DIGITS=4, CLK_DIV=4, DEAD_CYC=1
module tb_seg7_scan_driver;

    logic        clk = 1'b0;
    logic        rst_n, en, load;
    logic [15:0] data;
    logic [3:0]  dp, blank, an;
    logic [7:0]  seg;
    logic [1:0]  digit_idx;
    logic        frame_done;
    int          n_cmp = 0;
    int          n_bad = 0;

    seg7_scan_driver #(.DIGITS(4), .CLK_DIV(4), .DEAD_CYC(1)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .load       (load),
        .data       (data),
        .dp         (dp),
        .blank      (blank),
        .seg        (seg),
        .an         (an),
        .digit_idx  (digit_idx),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [7:0] s, input logic [3:0] a, input logic [1:0] i);
        chk({tag, ".seg"}, {24'b0, seg}, {24'b0, s});
        chk({tag, ".an"}, {28'b0, an}, {28'b0, a});
        chk({tag, ".idx"}, {30'b0, digit_idx}, {30'b0, i});
    endtask

`ifdef LZ_SUPPRESS_EN
    localparam logic [7:0] LZ_ZERO = 8'hFF;
`else
    localparam logic [7:0] LZ_ZERO = 8'hC0;
`endif

    initial begin
        rst_n = 1'b0; en = 1'b0; load = 1'b0; data = '0; dp = '0; blank = '0;
        step(2);
        chk_out("reset", 8'hFF, 4'hF, 2'd0);
        chk("reset.fd", {31'b0, frame_done}, 32'd0);
        rst_n = 1'b1;
        step(3);
        chk_out("idle_en0", 8'hFF, 4'hF, 2'd0);
        chk("idle_en0.fd", {31'b0, frame_done}, 32'd0);
        data = 16'h1234; load = 1'b1; en = 1'b1;
        step(1);
        load = 1'b0;
        chk_out("f1_d0", 8'h99, 4'hE, 2'd0);
        step(3);
        chk_out("f1_d0_last", 8'h99, 4'hE, 2'd0);
        step(1);
        chk_out("f1_gap0", 8'hFF, 4'hF, 2'd0);
        step(1);
        chk_out("f1_d1", 8'hB0, 4'hD, 2'd1);
        step(14);
        chk_out("f1_gap3", 8'hFF, 4'hF, 2'd3);
        chk("f1_gap3.fd", {31'b0, frame_done}, 32'd0);
        step(1);
        chk("wrap1.fd", {31'b0, frame_done}, 32'd1);
        chk_out("f2_d0", 8'h99, 4'hE, 2'd0);
        step(1);
        chk("wrap1_after.fd", {31'b0, frame_done}, 32'd0);
        step(19);
        chk("wrap2.fd", {31'b0, frame_done}, 32'd1);
        step(2);
        data = 16'hABCD; load = 1'b1;
        step(1);
        load = 1'b0;
        step(2);
        chk_out("midload_d1", 8'hB0, 4'hD, 2'd1);
        step(10);
        chk_out("midload_d3", 8'hF9, 4'h7, 2'd3);
        step(5);
        chk_out("newframe_d0", 8'hA1, 4'hE, 2'd0);
        step(5);
        chk_out("newframe_d1", 8'hC6, 4'hD, 2'd1);
        data = 16'h1234; dp = 4'b0100; blank = 4'b0001; load = 1'b1;
        step(1);
        load = 1'b0;
        step(14);
        chk_out("blank_d0", 8'hFF, 4'hE, 2'd0);
        step(10);
        chk_out("dp_d2", 8'h24, 4'hB, 2'd2);
        en = 1'b0;
        step(1);
        chk_out("en_drop", 8'hFF, 4'hF, 2'd0);
        step(2);
        chk_out("en_low_hold", 8'hFF, 4'hF, 2'd0);
        chk("en_low.fd", {31'b0, frame_done}, 32'd0);
        en = 1'b1;
        step(1);
        chk_out("restart_d0", 8'hFF, 4'hE, 2'd0);
        step(4);
        chk_out("restart_gap0", 8'hFF, 4'hF, 2'd0);
        step(1);
        chk_out("restart_d1", 8'hB0, 4'hD, 2'd1);
        data = 16'h0050; dp = '0; blank = '0; load = 1'b1;
        step(1);
        load = 1'b0;
        step(14);
        chk_out("lz_d0", 8'hC0, 4'hE, 2'd0);
        step(5);
        chk_out("lz_d1", 8'h92, 4'hD, 2'd1);
        step(5);
        chk_out("lz_d2", LZ_ZERO, 4'hB, 2'd2);
        step(5);
        chk_out("lz_d3", LZ_ZERO, 4'h7, 2'd3);
        rst_n = 1'b0;
        #2;
        chk_out("async_rst", 8'hFF, 4'hF, 2'd0);
        step(1);
        rst_n = 1'b1;
        step(1);
        chk_out("post_rst_d0", 8'hC0, 4'hE, 2'd0);
        step(5);
        chk_out("post_rst_d1", LZ_ZERO, 4'hD, 2'd1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
